// File: rtl/int_ctrl.sv
// Interrupt controller: synchronises and edge-detects external requests into a
// pending latch, masks and prioritises them, and runs a request/ack/rti handshake.
module int_ctrl #(
    parameter int NUM_SRC   = 4,
    parameter int VEC_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   irq_src,
    input  logic                 imask_we,
    input  logic [NUM_SRC-1:0]   imask_wdata,
    input  logic [NUM_SRC-1:0]   irptl_clr,
    input  logic                 ie,
    input  logic                 ps_idle,
    input  logic                 int_ack,
    input  logic                 rti,
    output logic                 interrupt,
    output logic [VEC_WIDTH-1:0] int_vec,
    output logic [NUM_SRC-1:0]   irptl,
    output logic [NUM_SRC-1:0]   imask,
    output logic                 in_service
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t               state, state_nxt;
    logic [VEC_WIDTH-1:0] vec_nxt;
    logic [NUM_SRC-1:0]   s1, s2, s3;
    logic [NUM_SRC-1:0]   edge_det;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   vec_onehot;
    logic [NUM_SRC-1:0]   ack_clr;
    logic [NUM_SRC-1:0]   irptl_nxt;
    logic [VEC_WIDTH-1:0] winner;
    logic                 ack_accept;
    logic                 req_ok;
    logic                 withdraw;

    assign edge_det   = s2 & ~s3;
    assign eligible   = irptl & imask;
    assign req_ok     = (|eligible) && (ie || ps_idle);
    assign ack_accept = (state == REQ) && int_ack;
    assign ack_clr    = ack_accept ? vec_onehot : '0;
    // A fresh edge beats any clear in the same cycle.
    assign irptl_nxt  = edge_det | (irptl & ~(irptl_clr | ack_clr));

    // The held request is withdrawn if its pending bit is cleared or its mask bit dropped.
    assign withdraw = (|(vec_onehot & irptl_clr & ~edge_det)) ||
                      (imask_we && (|(vec_onehot & ~imask_wdata)));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner     = '0;
        vec_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = VEC_WIDTH'(i);
            vec_onehot[i] = (int_vec == VEC_WIDTH'(i));
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = int_vec;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    state_nxt = REQ;
                    vec_nxt   = winner;
                end
            end
            REQ: begin
                if (int_ack)       state_nxt = SERVICE;
                else if (withdraw) state_nxt = IDLE;
            end
            SERVICE: begin
                if (rti) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            irptl      <= '0;
            imask      <= '0;
            state      <= IDLE;
            int_vec    <= '0;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
        end else begin
            s1         <= irq_src;
            s2         <= s1;
            s3         <= s2;
            irptl      <= irptl_nxt;
            if (imask_we) imask <= imask_wdata;
            state      <= state_nxt;
            int_vec    <= vec_nxt;
            interrupt  <= (state_nxt == REQ);
            in_service <= (state_nxt == SERVICE);
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: a table of per-cycle vectors run through a
// scoreboard queue, followed by hand-written multi-cycle corner-case sequences.
module tb_int_ctrl;

    localparam int N  = 4;
    localparam int VW = 3;
    localparam int NROWS = 20;

    typedef struct {
        logic [N-1:0]  irq;
        logic          we;
        logic [N-1:0]  wdata;
        logic [N-1:0]  clr;
        logic          ie;
        logic          ps;
        logic          ack;
        logic          rti;
        logic          e_int;
        logic [VW-1:0] e_vec;
        logic [N-1:0]  e_irptl;
        logic [N-1:0]  e_imask;
        logic          e_svc;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src, imask_wdata, irptl_clr;
    logic          imask_we, ie, ps_idle, int_ack, rti;
    logic          interrupt;
    logic [VW-1:0] int_vec;
    logic [N-1:0]  irptl, imask;
    logic          in_service;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t tbl[NROWS];
    vec_t sb_q[$];
    vec_t cur, exp_v;

    int_ctrl #(.NUM_SRC(N), .VEC_WIDTH(VW)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .imask_we   (imask_we),
        .imask_wdata(imask_wdata),
        .irptl_clr  (irptl_clr),
        .ie         (ie),
        .ps_idle    (ps_idle),
        .int_ack    (int_ack),
        .rti        (rti),
        .interrupt  (interrupt),
        .int_vec    (int_vec),
        .irptl      (irptl),
        .imask      (imask),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [N-1:0] irq, input logic we, input logic [N-1:0] wdata,
                                input logic [N-1:0] clr, input logic ie_i, input logic ps,
                                input logic ack, input logic rt, input logic e_int,
                                input logic [VW-1:0] e_vec, input logic [N-1:0] e_irptl,
                                input logic [N-1:0] e_imask, input logic e_svc);
        vec_t v;
        v.irq = irq;  v.we = we;  v.wdata = wdata;  v.clr = clr;
        v.ie = ie_i;  v.ps = ps;  v.ack = ack;  v.rti = rt;
        v.e_int = e_int;  v.e_vec = e_vec;  v.e_irptl = e_irptl;
        v.e_imask = e_imask;  v.e_svc = e_svc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses_off();
        imask_we  = 1'b0;
        irptl_clr = '0;
        int_ack   = 1'b0;
        rti       = 1'b0;
    endtask

    initial begin
        // Single source, then two simultaneous sources, then stray ack/rti in IDLE.
        //            irq    we wdata clr  ie ps ack rti   int vec irptl imask svc
        tbl[0]  = mk(4'h0, 1, 4'h1, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'h1, 0);
        tbl[1]  = mk(4'h1, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'h1, 0);
        tbl[2]  = mk(4'h1, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'h1, 0);
        tbl[3]  = mk(4'h1, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'h1, 4'h1, 0);
        tbl[4]  = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0,    1, 0, 4'h1, 4'h1, 0);
        tbl[5]  = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 1, 0,    0, 0, 4'h0, 4'h1, 1);
        tbl[6]  = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'h1, 1);
        tbl[7]  = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1,    0, 0, 4'h0, 4'h1, 0);
        tbl[8]  = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'h1, 0);
        tbl[9]  = mk(4'hA, 1, 4'hF, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'hF, 0);
        tbl[10] = mk(4'hA, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'h0, 4'hF, 0);
        tbl[11] = mk(4'hA, 0, 4'h0, 4'h0, 1, 0, 0, 0,    0, 0, 4'hA, 4'hF, 0);
        tbl[12] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0,    1, 1, 4'hA, 4'hF, 0);
        tbl[13] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 1, 0,    0, 1, 4'h8, 4'hF, 1);
        tbl[14] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1,    0, 1, 4'h8, 4'hF, 0);
        tbl[15] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 0,    1, 3, 4'h8, 4'hF, 0);
        tbl[16] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 1, 0,    0, 3, 4'h0, 4'hF, 1);
        tbl[17] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1,    0, 3, 4'h0, 4'hF, 0);
        tbl[18] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 1, 0,    0, 3, 4'h0, 4'hF, 0);
        tbl[19] = mk(4'h0, 0, 4'h0, 4'h0, 1, 0, 0, 1,    0, 3, 4'h0, 4'hF, 0);

        reset = 1'b0;
        irq_src = '0;  imask_wdata = '0;  ie = 1'b0;  ps_idle = 1'b0;
        pulses_off();
        #12;
        check("reset interrupt", interrupt, 0);
        check("reset int_vec", int_vec, 0);
        check("reset irptl", irptl, 0);
        check("reset imask", imask, 0);
        check("reset in_service", in_service, 0);
        #1 reset = 1'b1;
        tick();

        for (int i = 0; i < NROWS; i++) begin
            cur = tbl[i];
            irq_src = cur.irq;  imask_we = cur.we;  imask_wdata = cur.wdata;
            irptl_clr = cur.clr;  ie = cur.ie;  ps_idle = cur.ps;
            int_ack = cur.ack;  rti = cur.rti;
            sb_q.push_back(cur);
            tick();
            exp_v = sb_q.pop_front();
            check($sformatf("row%0d interrupt", i), interrupt, exp_v.e_int);
            check($sformatf("row%0d int_vec", i), int_vec, exp_v.e_vec);
            check($sformatf("row%0d irptl", i), irptl, exp_v.e_irptl);
            check($sformatf("row%0d imask", i), imask, exp_v.e_imask);
            check($sformatf("row%0d in_service", i), in_service, exp_v.e_svc);
        end
        pulses_off();
        irq_src = '0;

        // Masked source stays pending; ps_idle alone wakes it once unmasked.
        imask_we = 1'b1;  imask_wdata = 4'h0;  ie = 1'b1;
        tick();  pulses_off();
        irq_src = 4'h4;
        repeat (3) tick();
        irq_src = '0;
        tick();
        check("masked irptl", irptl, 4'h4);
        check("masked interrupt", interrupt, 0);
        ie = 1'b0;  ps_idle = 1'b0;  imask_we = 1'b1;  imask_wdata = 4'h4;
        tick();  pulses_off();
        check("unmask imask", imask, 4'h4);
        tick();
        check("ie0 no interrupt", interrupt, 0);
        ps_idle = 1'b1;
        tick();
        check("ps_idle interrupt", interrupt, 1);
        check("ps_idle int_vec", int_vec, 2);
        int_ack = 1'b1;  tick();  pulses_off();
        check("ps_idle ack svc", in_service, 1);
        check("ps_idle ack irptl", irptl, 0);
        rti = 1'b1;  tick();  pulses_off();
        check("ps_idle rti svc", in_service, 0);
        ps_idle = 1'b0;  ie = 1'b1;

        // Withdrawal by irptl_clr; a later ack must be ignored.
        imask_we = 1'b1;  imask_wdata = 4'h1;  tick();  pulses_off();
        irq_src = 4'h1;  repeat (3) tick();
        irq_src = '0;  tick();
        check("wd clr raise", interrupt, 1);
        check("wd clr vec", int_vec, 0);
        irptl_clr = 4'h1;  tick();  pulses_off();
        check("wd clr interrupt", interrupt, 0);
        check("wd clr irptl", irptl, 0);
        int_ack = 1'b1;  tick();  pulses_off();
        check("wd stray ack svc", in_service, 0);
        check("wd stray ack int", interrupt, 0);

        // Withdrawal by masking: pending bit retained, re-requested once unmasked.
        repeat (2) tick();
        irq_src = 4'h1;  repeat (3) tick();
        irq_src = '0;  tick();
        check("wd mask raise", interrupt, 1);
        imask_we = 1'b1;  imask_wdata = 4'h0;  tick();  pulses_off();
        check("wd mask interrupt", interrupt, 0);
        check("wd mask retained", irptl, 4'h1);
        imask_we = 1'b1;  imask_wdata = 4'h1;  tick();  pulses_off();
        check("remask same cycle", interrupt, 0);
        tick();
        check("remask raise", interrupt, 1);
        int_ack = 1'b1;  tick();  pulses_off();
        check("remask ack svc", in_service, 1);

        // New edge on the serviced source lands on the same edge as rti.
        tick();
        irq_src = 4'h1;  tick();  tick();
        rti = 1'b1;  tick();  pulses_off();
        irq_src = '0;
        check("collide irptl", irptl, 4'h1);
        check("collide svc", in_service, 0);
        check("collide int low", interrupt, 0);
        tick();
        check("collide re-raise", interrupt, 1);
        check("collide vec", int_vec, 0);
        int_ack = 1'b1;  tick();  pulses_off();
        rti = 1'b1;  tick();  pulses_off();
        check("collide done svc", in_service, 0);

        // Edge and clear on the same cycle keep the bit set.
        irq_src = 4'h2;  tick();  tick();
        irptl_clr = 4'h2;  tick();  pulses_off();
        irq_src = '0;
        check("edge+clr irptl", irptl, 4'h2);
        irptl_clr = 4'h2;  tick();  pulses_off();
        check("clr alone irptl", irptl, 0);
        check("masked src1 no int", interrupt, 0);

        // Asynchronous reset between clock edges while in REQ.
        tick();  tick();
        irq_src = 4'h1;  repeat (3) tick();
        irq_src = '0;  tick();
        check("pre-reset raise", interrupt, 1);
        #2 reset = 1'b0;
        #1;
        check("async interrupt", interrupt, 0);
        check("async irptl", irptl, 0);
        check("async imask", imask, 0);
        check("async in_service", in_service, 0);
        check("async int_vec", int_vec, 0);
        #2 reset = 1'b1;
        repeat (4) tick();
        check("post-reset interrupt", interrupt, 0);
        check("post-reset irptl", irptl, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that sits directly upstream of the core's single `interrupt` input. It synchronises NUM_SRC asynchronous external request lines and edge-detects them into a pending latch. It applies a core-written mask, picks the highest-priority unmasked pending source, and holds `interrupt` high with a stable vector until the core acknowledges. It tracks one in-service interrupt (no nesting) until the core signals return-from-interrupt.

## Interface
- NUM_SRC, 4: number of external interrupt sources (1..8).
- VEC_WIDTH, 3: width of vector index; must satisfy 2^VEC_WIDTH >= NUM_SRC.
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- irq_src  input  NUM_SRC  asynchronous request lines; rising edge = request.
- imask_we  input  1  write strobe for mask register.
- imask_wdata  input  NUM_SRC  new mask; 1 = source enabled.
- irptl_clr  input  NUM_SRC  one-cycle pulses; clears matching pending bits.
- ie  input  1  global interrupt enable from program sequencer.
- ps_idle  input  1  core is in IDLE; allows wake even when ie=0.
- int_ack  input  1  one-cycle pulse; core has vectored to int_vec.
- rti  input  1  one-cycle pulse; core returned from the service routine.
- interrupt  output  1  request to core (registered).
- int_vec  output  VEC_WIDTH  index of the requested/in-service source (registered).
- irptl  output  NUM_SRC  pending latch, readable by core.
- imask  output  NUM_SRC  current mask register.
- in_service  output  1  high from ack until rti.

## Operation
- Reset values: interrupt=0, int_vec=0, irptl=0, imask=0, in_service=0. Synchronisers and edge-history flops=0. FSM state=IDLE.
- Each irq_src bit passes through a 2-flop synchroniser (s1, s2), then a history flop s3. A rising edge is s2 & ~s3.
- Pending update per bit, in priority order:
  - Set on a detected edge.
  - Otherwise clear on irptl_clr, or on an accepted int_ack for that bit.
  - Otherwise hold.
  - An edge and a clear in the same cycle leave the bit set.
- Mask: an imask_we write takes effect the next cycle. Masked pending bits are retained, never dropped.
- Eligible set: irptl & imask. Priority is fixed: lowest index wins.
- Request condition: eligible set non-empty AND (ie OR ps_idle).
- FSM:
  - IDLE: if the request condition holds, register interrupt=1, latch int_vec=winner, go to REQ.
  - REQ: interrupt and int_vec held stable and are not re-arbitrated.
    - On int_ack: interrupt=0, clear irptl[int_vec], in_service=1, go to SERVICE.
    - If irptl[int_vec] is cleared by irptl_clr or imask_we before ack: interrupt=0, go to IDLE (request withdrawn).
  - SERVICE: no new requests are raised. On rti: in_service=0, go to IDLE. int_vec keeps the serviced index until the next request.
- int_ack outside REQ and rti outside SERVICE are ignored.
- ie=0 while in REQ does not withdraw the request.

## Timing
- Edge-to-pending latency: irq_src high sampled at edge E0 gives s1 at E0, s2 at E1, and irptl bit set at E2.
- Pending-to-request latency: interrupt high after E3 (one cycle after irptl is visible). Total is 3 edges from first sample.
- Ack: interrupt low and irptl bit cleared on the same edge that samples int_ack.
- Back-to-back: after rti at edge En, the FSM is IDLE at En and may assert interrupt at En+1 if eligible.
- irq_src must stay high at least 2 clk periods to be guaranteed captured. It must go low for at least 2 periods before a new edge is recognised.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). Pending requests are lost.

## Test plan
- Single source: imask=4'b0001, ie=1, pulse irq_src[0] for 3 cycles.
  - Required: irptl[0]=1 at E2 and interrupt=1, int_vec=0 at E3.
  - After int_ack: interrupt=0, irptl=0, in_service=1.
  - After rti: in_service=0.
- Priority: imask=4'b1111, raise irq_src[3] and irq_src[1] on the same edge.
  - Required: int_vec=1 first. After ack and rti, int_vec=3 is requested on the next cycle.
- Mask/idle:
  - imask=0, edge on irq_src[2]: irptl[2]=1 and interrupt stays 0.
  - Write imask=4'b0100 with ie=0, ps_idle=0: still no interrupt.
  - Set ps_idle=1: interrupt=1 one cycle later, int_vec=2.
- Withdrawal: in REQ for source 0, pulse irptl_clr=4'b0001. Required: interrupt=0 next edge, FSM IDLE, a later int_ack is ignored.
- Collision: in SERVICE, a new edge on the serviced source arrives on the same edge as rti. Required: irptl bit set, interrupt re-raised one cycle after rti.
- Async reset: assert reset low mid-REQ, between clock edges. Required: interrupt, irptl, imask and in_service go to 0 immediately; no request after release without new edges.
